// File: rtl/mux_pkg.sv
// Shared mode encodings for the round-robin / fixed-select arbiter mux.
package mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Purpose: rotating priority search; first set req bit after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own slot availability.
module rr_pick #(
    parameter  int CH = 3,
    localparam int SW = $clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);
    // Walk from the farthest candidate back to the nearest so the nearest one wins.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = CH; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % CH]) begin
                gnt_idx = SW'((int'(ptr) + i) % CH);
                gnt_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arb_mux.sv
// Purpose: CH-input arbiter mux, fixed-select or round-robin, into one output register.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: inputs accepted only when the register is empty or draining this cycle.
module rr_arb_mux
    import mux_pkg::*;
#(
    parameter  int N  = 32,
    parameter  int CH = 3,
    localparam int SW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic [N-1:0]    out_data,
    output logic [SW-1:0]   out_chan,
    output logic            out_valid,
    input  logic            out_ready
);
    localparam int SELW = 1 << SW;

    logic [SW-1:0]   ptr;
    logic [SW-1:0]   pick_idx;
    logic            pick_any;
    logic [SELW-1:0] vld_pad;
    logic            sel_ok;
    logic            slot_free;
    logic [SW-1:0]   gnt;
    logic            gnt_any;
    logic            take;

    rr_pick #(.CH(CH)) u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Padding lets sel index safely when CH is not a power of two.
    assign vld_pad   = SELW'(in_valid);
    assign sel_ok    = int'(sel) < CH;
    assign slot_free = !out_valid || out_ready;

    assign gnt     = (mode == MODE_FIXED) ? sel : pick_idx;
    assign gnt_any = (mode == MODE_RR) ? pick_any : (sel_ok && vld_pad[sel]);
    assign take    = gnt_any && slot_free && !reset;

    assign in_ready = take ? (CH'(1) << gnt) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SW'(CH - 1);
        end else begin
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(gnt)*N +: N];
                out_chan  <= gnt;
                if (mode == MODE_RR) begin
                    ptr <= gnt;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
